vga_box_mover: RTL and testbench

Upstream control stage for the 640x480 VGA pattern generator. It turns four raw pushbuttons into the top-left coordinate of the 41x31 green marker box. Coordinates are active-area pixel positions, the same space as the renderer's `xpos`/`ypos`. The marker moves once per frame, and its position is clamped so the box never touches the blue border (x 120..520, y 80..400).

---
 rtl/vga_box_mover.sv | 132 +++++++++++++
 tb/tb_vga_box_mover.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_box_mover.sv
// Pushbutton-driven marker position for the VGA pattern generator: debounced
// buttons move a box once per frame, clamped inside the blue border.

module vga_box_db #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clock,
  input  logic rst_n,
  input  logic btn_n,
  output logic pressed
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;

  assign level = ~sync[1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 2'b11;
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync <= {sync[0], btn_n};
      if (level == pressed) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        pressed <= ~pressed;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module vga_box_mover #(
  parameter int BOX_W     = 41,
  parameter int BOX_H     = 31,
  parameter int X_MIN     = 141,
  parameter int X_MAX     = 499,
  parameter int Y_MIN     = 101,
  parameter int Y_MAX     = 379,
  parameter int X_INIT    = 285,
  parameter int Y_INIT    = 225,
  parameter int STEP      = 2,
  parameter int DB_CYCLES = 500000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       btn_up_n,
  input  logic       btn_dn_n,
  input  logic       btn_lt_n,
  input  logic       btn_rt_n,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       frame_tick,
  output logic       wall_hit,
  output logic [3:0] btn_state
);
  localparam logic signed [10:0] X_LO = 11'(X_MIN);
  localparam logic signed [10:0] X_HI = 11'(X_MAX - BOX_W + 1);
  localparam logic signed [10:0] Y_LO = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI = 11'(Y_MAX - BOX_H + 1);
  localparam logic signed [10:0] STP  = 11'(STEP);

  logic [3:0] btn_raw;
  assign btn_raw = {btn_up_n, btn_dn_n, btn_lt_n, btn_rt_n};

  vga_box_db #(.DB_CYCLES(DB_CYCLES)) u_db [3:0] (
    .clock  (clock),
    .rst_n  (rst_n),
    .btn_n  (btn_raw),
    .pressed(btn_state)
  );

  // Sync flops reset high so a vsync already high after reset gives no edge.
  logic vs_s0, vs_s1, vs_d;
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vs_s0      <= 1'b1;
      vs_s1      <= 1'b1;
      vs_d       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_s0      <= vsync;
      vs_s1      <= vs_s0;
      vs_d       <= vs_s1;
      frame_tick <= vs_s1 & ~vs_d;
    end
  end

  logic signed [10:0] dx, dy, tx, ty, nx, ny;
  logic               clamp;

  always_comb begin
    dx = '0;
    dy = '0;
    case ({btn_state[0], btn_state[1]})  // {rt, lt}
      2'b10:   dx = STP;
      2'b01:   dx = -STP;
      default: dx = '0;
    endcase
    case ({btn_state[2], btn_state[3]})  // {dn, up}
      2'b10:   dy = STP;
      2'b01:   dy = -STP;
      default: dy = '0;
    endcase
    tx = $signed({1'b0, box_x}) + dx;
    ty = $signed({1'b0, box_y}) + dy;
    nx = (tx < X_LO) ? X_LO : (tx > X_HI) ? X_HI : tx;
    ny = (ty < Y_LO) ? Y_LO : (ty > Y_HI) ? Y_HI : ty;
    clamp = (nx != tx) || (ny != ty);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      box_x    <= 10'(X_INIT);
      box_y    <= 10'(Y_INIT);
      wall_hit <= 1'b0;
    end else begin
      wall_hit <= frame_tick & clamp;
      if (frame_tick) begin
        box_x <= nx[9:0];
        box_y <= ny[9:0];
      end
    end
  end
endmodule

// File: tb/tb_vga_box_mover.sv
// Scoreboard bench for vga_box_mover: frames push expected positions, a
// monitor compares them on the cycle after each frame_tick.

module tb_vga_box_mover;
  logic       clock = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       btn_up_n, btn_dn_n, btn_lt_n, btn_rt_n;
  logic [9:0] box_x, box_y;
  logic       frame_tick, wall_hit;
  logic [3:0] btn_state;

  typedef struct {
    int x;
    int y;
    int wh;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  vga_box_mover #(.DB_CYCLES(4)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .btn_up_n  (btn_up_n),
    .btn_dn_n  (btn_dn_n),
    .btn_lt_n  (btn_lt_n),
    .btn_rt_n  (btn_rt_n),
    .box_x     (box_x),
    .box_y     (box_y),
    .frame_tick(frame_tick),
    .wall_hit  (wall_hit),
    .btn_state (btn_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: position and wall_hit are compared the cycle after each tick.
  always @(negedge clock) begin
    if (frame_tick) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("box_x", int'(box_x), e.x);
        check("box_y", int'(box_y), e.y);
        check("wall_hit", int'(wall_hit), e.wh);
      end
    end
  end

  // One 60-cycle vsync period; optionally pulses reset while vsync is high.
  task automatic frame(input int ex, input int ey, input int ewh, input bit rst_mid);
    int   n;
    bit   got;
    exp_t e;
    e.x = ex; e.y = ey; e.wh = ewh;
    exp_q.push_back(e);
    vsync = 1'b1;
    n = 0;
    got = 0;
    while (!got && n < 10) begin
      @(posedge clock);
      n++;
      #1;
      if (frame_tick) got = 1;
    end
    check("tick_latency", got ? n : -1, 3);
    @(negedge clock);
    repeat (10) @(negedge clock);
    if (rst_mid) begin
      rst_n = 1'b0;
      #2;
      check("rst_async_x", int'(box_x), 285);
      check("rst_async_y", int'(box_y), 225);
      check("rst_btn_state", int'(btn_state), 0);
      @(negedge clock);
      rst_n = 1'b1;
    end
    repeat (16) @(negedge clock);
    vsync = 1'b0;
    repeat (30) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  initial begin
    rst_n = 1'b0;
    vsync = 1'b0;
    btn_up_n = 1'b1; btn_dn_n = 1'b1; btn_lt_n = 1'b1; btn_rt_n = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_box_x", int'(box_x), 285);
    check("reset_box_y", int'(box_y), 225);
    check("reset_tick", int'(frame_tick), 0);
    check("reset_wall", int'(wall_hit), 0);
    check("reset_btn", int'(btn_state), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clock);

    // idle frames
    for (int k = 0; k < 3; k++) frame(285, 225, 0, 0);

    // right press: debounce in 6 cycles, then three steps
    btn_rt_n = 1'b0;
    repeat (5) @(negedge clock);
    check("db_rt_early", int'(btn_state), 4'b0000);
    @(negedge clock);
    check("db_rt_done", int'(btn_state), 4'b0001);
    repeat (4) @(negedge clock);
    frame(287, 225, 0, 0);
    frame(289, 225, 0, 0);
    frame(291, 225, 0, 0);
    btn_rt_n = 1'b1;
    repeat (10) @(negedge clock);

    // up held from reset: walk into the top limit
    btn_up_n = 1'b0;
    do_reset();
    repeat (10) @(negedge clock);
    for (int k = 1; k <= 70; k++)
      frame(285, (225 - 2 * k < 101) ? 101 : 225 - 2 * k, (k >= 63) ? 1 : 0, 0);
    btn_up_n = 1'b1;
    repeat (10) @(negedge clock);

    // left and right together cancel
    btn_lt_n = 1'b0;
    btn_rt_n = 1'b0;
    repeat (10) @(negedge clock);
    check("db_lt_rt", int'(btn_state), 4'b0011);
    for (int k = 0; k < 5; k++) frame(285, 101, 0, 0);
    btn_lt_n = 1'b1;
    btn_rt_n = 1'b1;
    repeat (10) @(negedge clock);

    // 3-cycle glitch on down is filtered
    btn_dn_n = 1'b0;
    repeat (3) @(negedge clock);
    btn_dn_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("glitch_btn", int'(btn_state), 0);
    end
    frame(285, 101, 0, 0);

    // right held, reset pulsed mid-frame at 295, then resume from 285
    do_reset();
    btn_rt_n = 1'b0;
    repeat (10) @(negedge clock);
    frame(287, 225, 0, 0);
    frame(289, 225, 0, 0);
    frame(291, 225, 0, 0);
    frame(293, 225, 0, 0);
    frame(295, 225, 0, 1);
    check("post_rst_x", int'(box_x), 285);
    check("post_rst_btn", int'(btn_state), 4'b0001);
    frame(287, 225, 0, 0);
    btn_rt_n = 1'b1;
    repeat (10) @(negedge clock);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
